mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data RAM interface. Accepts one load/store request at a time from the CPU
//  (valid/ready), drives word-addressed RAM signals (address, write data, write enable) and returns
//  load data or store completion (valid/ready). Byte/halfword loads are extracted and extended;
//  byte/halfword stores use read-modify-write. Little-endian.
// PARAMETERS
//  DATA_WIDTH  32  RAM word width; fixed 32 (4 byte lanes)
//  ADDR_WIDTH  16  RAM word-address width; CPU byte address is ADDR_WIDTH+2 bits
// PORTS
//  Clock           in   1             single clock; also drives RAM write (negedge) and read (posedge)
//  Reset           in   1             synchronous, active-low
//  Req_Valid       in   1             request present
//  Req_Ready       out  1             unit can accept (IDLE only)
//  Req_Write       in   1             1 = store, 0 = load
//  Req_Size        in   2             00 byte, 01 half, 10 word, 11 = treated as word
//  Req_Unsigned    in   1             load: 1 zero-extend, 0 sign-extend
//  Req_Addr        in   ADDR_WIDTH+2  byte address
//  Req_Data        in   32            store data (low bytes used for sub-word)
//  Resp_Valid      out  1             response present; held until Resp_Ready
//  Resp_Ready      in   1             CPU accepts response
//  Resp_Data       out  32            load result; 0 for stores
//  Resp_Fault      out  1             misaligned access (MEM_MISALIGN_TRAP_EN only, else 0)
//  Mem_Address     out  ADDR_WIDTH    word address = Req_Addr[ADDR_WIDTH+1:2]
//  Mem_Write_Data  out  32            word to write
//  Mem_Write       out  1             RAM write enable, sampled at falling edge
//  Mem_Read_Data   in   32            RAM read data, valid cycle after address presented
// BEHAVIOUR
//  - States: IDLE, READ, RD_WAIT, WRITE, DONE. Request fields captured at handshake (Req_Valid&&Req_Ready).
//  - IDLE->WRITE for word store; IDLE->READ for load or sub-word store.
//  - READ: Mem_Address driven, Mem_Write=0 -> RD_WAIT. RD_WAIT: capture Mem_Read_Data;
//    load -> DONE with extracted data; sub-word store -> WRITE with merged word.
//  - WRITE: Mem_Write=1 exactly one cycle, Mem_Address/Mem_Write_Data stable whole cycle -> DONE.
//  - DONE: Resp_Valid=1, Resp_Data/Resp_Fault stable; on Resp_Ready -> IDLE. No new request in same cycle.
//  - Latency handshake->Resp_Valid: word store 2, load 3, sub-word store 4 cycles.
//  - Lanes: byte lane=addr[1:0], half lane=addr[1]; untouched lanes preserved on merge.
//  - Mem_Write = (state==WRITE) && Reset: reset low during WRITE suppresses the negedge write.
//  - Reset (sampled low at posedge): state->IDLE, abandon in-flight op, no response issued.
//    Outputs while/after reset: Req_Ready 0 during reset then 1, Resp_Valid 0, Resp_Data 0,
//    Resp_Fault 0, Mem_Write 0, Mem_Address 0, Mem_Write_Data 0.
//  - Mem_Address/Mem_Write_Data are 0 in IDLE and DONE.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE, no RAM
//    access, Resp_Fault=1, Resp_Data=0. Size 11 checked as word.
//  Undefined: misaligned low bits ignored (half uses addr[1], word ignores addr[1:0]); Resp_Fault tied 0.
// STRUCTURE
//  mem_access_defs.vh: size encodings, state encodings, lane-index localparams.
//  Sub-module mem_lane_align (combinational): load extract/extend and store merge by size/lane.
// TESTING
//  1 Word store 0xDEADBEEF @0x0010 -> Mem_Write one cycle, Mem_Address=0x0004; Resp_Valid 2 cycles later.
//  2 Load word @0x0010 after 1 -> Resp_Data=0xDEADBEEF 3 cycles after handshake.
//  3 Byte store 0x55 @0x0012 over 0xDEADBEEF -> RAM word 0xDE55BEEF; signed byte load @0x0013 -> 0xFFFFFFDE.
//  4 Half load unsigned @0x0012 of 0xDE55BEEF -> 0x0000DE55; signed -> 0xFFFFDE55.
//  5 Reset low during WRITE of word store -> no RAM change, Resp_Valid 0, Req_Ready 1 after release.
//  6 Resp_Ready held 0 for 5 cycles -> Resp_Valid/Resp_Data stable, Req_Ready 0; MEM_MISALIGN_TRAP_EN:
//    word load @0x0011 -> Resp_Fault=1, Resp_Data=0, no Mem_Write, next cycle after handshake.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-RAM access unit: access-size codes,
// FSM state codes, byte-lane geometry and the alignment helper.
package mem_access_unit_pkg;

  // Geometry of one RAM word: four little-endian byte lanes.
  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam int NUM_LANES = 4;
  localparam int LANE_BITS = 2;

  // Request size codes. The code 2'b11 is handled as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // FSM state codes.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Both 2'b10 and 2'b11 denote a full-word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  // Halves must sit on an even byte address, words on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [LANE_BITS-1:0] lane);
    logic bad;
    bad = 1'b0;
    if (is_word(size))
      bad = (lane != 2'b00);
    else if (size == SZ_HALF)
      bad = lane[0];
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the access unit.
// Load path: pick the addressed byte/half out of the RAM word and
// zero- or sign-extend it. Store path: splice the low bytes of the store
// data into the addressed lanes of the old word, keeping the other lanes.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]           i_size,
  input  logic [LANE_BITS-1:0] i_lane,
  input  logic                 i_unsigned,
  input  logic [WORD_BITS-1:0] i_rd_word,
  input  logic [WORD_BITS-1:0] i_st_data,
  output logic [WORD_BITS-1:0] o_load_data,
  output logic [WORD_BITS-1:0] o_merged_word
);

  logic [NUM_LANES-1:0] w_lane_en;
  logic [WORD_BITS-1:0] w_st_repl;
  logic [4:0]           w_shift;
  logic [WORD_BITS-1:0] w_shifted;

  // Lane enables and replicated store data; a half uses only addr[1]
  // to pick its lane pair, so an odd half address is never split.
  always_comb begin
    w_lane_en = 4'b1111;
    w_st_repl = i_st_data;
    w_shift   = 5'd0;
    case (i_size)
      SZ_BYTE: begin
        w_lane_en = 4'b0001 << i_lane;
        w_st_repl = {NUM_LANES{i_st_data[7:0]}};
        w_shift   = {i_lane, 3'b000};
      end
      SZ_HALF: begin
        w_lane_en = i_lane[1] ? 4'b1100 : 4'b0011;
        w_st_repl = {2{i_st_data[15:0]}};
        w_shift   = {i_lane[1], 4'b0000};
      end
      default: begin
        w_lane_en = 4'b1111;
        w_st_repl = i_st_data;
        w_shift   = 5'd0;
      end
    endcase
  end

  // Read-modify-write merge, one byte lane at a time.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign o_merged_word[gi*BYTE_BITS +: BYTE_BITS] =
        w_lane_en[gi] ? w_st_repl[gi*BYTE_BITS +: BYTE_BITS]
                      : i_rd_word[gi*BYTE_BITS +: BYTE_BITS];
    end
  endgenerate

  assign w_shifted = i_rd_word >> w_shift;

  // Extend the shifted-down load value to a full word.
  always_comb begin
    o_load_data = w_shifted;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one load/store at a time over valid/ready, word-
// addressed RAM with a negedge write and a registered (next-cycle) read.
// Sub-word stores are done as read-modify-write.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests skip the RAM and answer at once with Resp_Fault=1.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Unsigned,
  input  logic [ADDR_WIDTH+1:0] Req_Addr,
  input  logic [DATA_WIDTH-1:0] Req_Data,
  output logic                  Resp_Valid,
  input  logic                  Resp_Ready,
  output logic [DATA_WIDTH-1:0] Resp_Data,
  output logic                  Resp_Fault,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic                  Mem_Write,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

  logic [2:0]            r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_fault;

  logic [2:0]            w_state_next;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_in_done;
  logic                  w_addr_live;
  logic                  w_wr_live;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged_word;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(Req_Size, Req_Addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign Req_Ready = (r_state == ST_IDLE) && Reset;
  assign w_accept  = Req_Valid && Req_Ready;

  // Next-state: word stores go straight to WRITE, everything else reads first.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misalign)
            w_state_next = ST_DONE;
          else if (Req_Write && is_word(Req_Size))
            w_state_next = ST_WRITE;
          else
            w_state_next = ST_READ;
        end
      end
      ST_READ:    w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: w_state_next = r_write ? ST_WRITE : ST_DONE;
      ST_WRITE:   w_state_next = ST_DONE;
      ST_DONE:    w_state_next = Resp_Ready ? ST_IDLE : ST_DONE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State register plus request capture and RAM-data capture; reset abandons
  // any in-flight access without producing a response.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write     <= Req_Write;
            r_size      <= Req_Size;
            r_unsigned  <= Req_Unsigned;
            r_addr      <= Req_Addr;
            r_wdata     <= Req_Data;
            r_resp_data <= '0;
            r_fault     <= w_misalign;
          end
        end
        ST_RD_WAIT: begin
          if (r_write)
            r_wdata <= w_merged_word;
          else
            r_resp_data <= w_load_data;
        end
        default: ;
      endcase
    end
  end

  mem_lane_align u_lane_align (
    .i_size        (r_size),
    .i_lane        (r_addr[1:0]),
    .i_unsigned    (r_unsigned),
    .i_rd_word     (Mem_Read_Data),
    .i_st_data     (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  // Outputs are forced to zero while reset is held, even mid-access, so a
  // reset asserted during WRITE kills that cycle's negedge write.
  assign w_in_done   = (r_state == ST_DONE) && Reset;
  assign w_wr_live   = (r_state == ST_WRITE) && Reset;
  assign w_addr_live = Reset && ((r_state == ST_READ) || (r_state == ST_RD_WAIT) ||
                                 (r_state == ST_WRITE));

  assign Resp_Valid     = w_in_done;
  assign Resp_Data      = w_in_done ? r_resp_data : '0;
  assign Resp_Fault     = w_in_done && r_fault;
  assign Mem_Write      = w_wr_live;
  assign Mem_Write_Data = w_wr_live ? r_wdata : '0;
  assign Mem_Address    = w_addr_live ? r_addr[ADDR_WIDTH+1:2] : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit. A byte-level reference model (shadow RAM plus
// latency rules) is checked against the DUT every cycle; directed requests
// also check hand-computed literals. Honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [17:0] req_addr;
  logic [31:0] req_data;
  logic        req_ready, resp_valid, resp_fault, mem_write;
  logic [31:0] resp_data, mem_wdata, mem_rdata;
  logic [15:0] mem_address;

  logic [31:0] ram     [0:65535];
  logic [31:0] exp_mem [0:65535];

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  // Model state: an accepted request and how many cycles have passed since.
  logic        m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_lat = 0;
  logic        m_store = 1'b0;
  logic        m_fault = 1'b0;
  logic [15:0] m_wa = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_wword = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .Clock(clk), .Reset(rst_n),
    .Req_Valid(req_valid), .Req_Ready(req_ready), .Req_Write(req_write),
    .Req_Size(req_size), .Req_Unsigned(req_unsigned), .Req_Addr(req_addr),
    .Req_Data(req_data), .Resp_Valid(resp_valid), .Resp_Ready(resp_ready),
    .Resp_Data(resp_data), .Resp_Fault(resp_fault), .Mem_Address(mem_address),
    .Mem_Write_Data(mem_wdata), .Mem_Write(mem_write), .Mem_Read_Data(mem_rdata)
  );

  // Behavioural RAM: write at falling edge, registered read at rising edge.
  always @(negedge clk) if (mem_write) ram[mem_address] <= mem_wdata;
  always @(posedge clk) mem_rdata <= ram[mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] a);
    logic [7:0] b [4];
    logic [31:0] v;
    int lo;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    lo = a[1] ? 2 : 0;
    if (sz == 2'b00) begin
      v = {24'h0, b[a]};
      if (!uns && b[a][7]) v[31:8] = '1;
    end else if (sz == 2'b01) begin
      v = {16'h0, b[lo+1], b[lo]};
      if (!uns && b[lo+1][7]) v[31:16] = '1;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    int lo;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    lo = a[1] ? 2 : 0;
    if (sz == 2'b00) b[a] = d[7:0];
    else if (sz == 2'b01) begin b[lo] = d[7:0]; b[lo+1] = d[15:8]; end
    else return d;
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic mdl_misaligned(input logic [1:0] sz, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Model tracker: accept requests, count cycles, commit stores to shadow RAM.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_cyc   <= 1;
        m_store <= req_write;
        m_wa    <= req_addr[17:2];
        m_fault <= mdl_misaligned(req_size, req_addr[1:0]);
        if (mdl_misaligned(req_size, req_addr[1:0])) begin
          m_lat  <= 1;
          m_data <= 32'h0;
        end else if (!req_write) begin
          m_lat  <= 3;
          m_data <= mdl_load(exp_mem[req_addr[17:2]], req_size, req_unsigned, req_addr[1:0]);
        end else begin
          m_lat  <= req_size[1] ? 2 : 4;
          m_data <= 32'h0;
        end
        m_wword <= mdl_store(exp_mem[req_addr[17:2]], req_size, req_addr[1:0], req_data);
      end
    end else if (m_cyc >= m_lat) begin
      if (resp_ready) m_busy <= 1'b0;
    end else begin
      if (m_store && !m_fault && m_cyc == m_lat - 1) exp_mem[m_wa] <= m_wword;
      m_cyc <= m_cyc + 1;
    end
  end

  // Compare process: every falling edge once reset has been applied.
  logic e_ready, e_valid, e_we, e_addr_live;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ready     = rst_n && !m_busy;
      e_valid     = rst_n && m_busy && (m_cyc >= m_lat);
      e_we        = rst_n && m_busy && m_store && !m_fault && (m_cyc == m_lat - 1);
      e_addr_live = rst_n && m_busy && (m_cyc < m_lat);
      chk("req_ready",  32'(req_ready),  32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_valid));
      chk("resp_data",  resp_data, e_valid ? m_data : 32'h0);
      chk("resp_fault", 32'(resp_fault), 32'(e_valid && m_fault));
      chk("mem_write",  32'(mem_write),  32'(e_we));
      chk("mem_addr",   32'(mem_address), e_addr_live ? 32'(m_wa) : 32'h0);
      if (e_we) chk("mem_wdata", mem_wdata, m_wword);
      else if (!e_addr_live) chk("mem_wdata_idle", mem_wdata, 32'h0);
    end
  end

  // One request end to end; returns data, fault and handshake-to-valid latency.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [17:0] a, input logic [31:0] d, input int hold,
                         output logic [31:0] rd, output logic flt, output int lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = 32'h0; flt = 1'b0;
    if (!resp_valid) begin
      chk("resp_timeout", 32'(resp_valid), 32'h1);
    end else begin
      for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
      rd = resp_data; flt = resp_fault;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
    $display("req w=%0b sz=%0d u=%0b addr=%05h data=%08h -> resp=%08h fault=%0b lat=%0d",
             w, sz, uns, a, d, rd, flt, lat);
  endtask

  logic [31:0] rd;
  logic flt;
  int lat;

  initial begin
    for (int i = 0; i < 65536; i++) begin ram[i] = 32'h0; exp_mem[i] = 32'h0; end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: word store
    run_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 0, rd, flt, lat);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_ram", ram[4], 32'hDEADBEEF);
    chk("t1_model", exp_mem[4], 32'hDEADBEEF);
    // 2: word load
    run_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 0, rd, flt, lat);
    chk("t2_data", rd, 32'hDEADBEEF);
    chk("t2_lat", 32'(lat), 32'd3);
    // 3: byte store (read-modify-write) then signed byte load
    run_req(1'b1, 2'b00, 1'b0, 18'h00012, 32'h00000055, 0, rd, flt, lat);
    chk("t3_lat", 32'(lat), 32'd4);
    chk("t3_ram", ram[4], 32'hDE55BEEF);
    chk("t3_model", exp_mem[4], 32'hDE55BEEF);
    run_req(1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 0, rd, flt, lat);
    chk("t3_byte_s", rd, 32'hFFFFFFDE);
    // 4: half loads, both extensions; plus more lanes
    run_req(1'b0, 2'b01, 1'b1, 18'h00012, 32'h0, 0, rd, flt, lat);
    chk("t4_half_u", rd, 32'h0000DE55);
    run_req(1'b0, 2'b01, 1'b0, 18'h00012, 32'h0, 0, rd, flt, lat);
    chk("t4_half_s", rd, 32'hFFFFDE55);
    run_req(1'b0, 2'b00, 1'b1, 18'h00010, 32'h0, 0, rd, flt, lat);
    chk("t4_byte0_u", rd, 32'h000000EF);
    run_req(1'b0, 2'b00, 1'b0, 18'h00011, 32'h0, 0, rd, flt, lat);
    chk("t4_byte1_s", rd, 32'hFFFFFFBE);
    run_req(1'b1, 2'b01, 1'b0, 18'h00020, 32'hA5A51234, 0, rd, flt, lat);
    chk("t4_half_st", ram[8], 32'h00001234);
    run_req(1'b1, 2'b01, 1'b0, 18'h00022, 32'h0000C3D2, 0, rd, flt, lat);
    chk("t4_half_hi_st", ram[8], 32'hC3D21234);

    // 5: reset during the WRITE cycle of a word store
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 18'h00010; req_data = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready", 32'(req_ready), 32'h1);
    chk("t5_valid", 32'(resp_valid), 32'h0);
    chk("t5_ram", ram[4], 32'hDE55BEEF);
    $display("req reset-during-write addr=00010 -> ram[4]=%08h", ram[4]);

    // 6: response held for 5 cycles (stability checked every cycle)
    run_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 5, rd, flt, lat);
    chk("t6_data", rd, 32'hDE55BEEF);
    run_req(1'b0, 2'b11, 1'b0, 18'h00010, 32'h0, 0, rd, flt, lat);
    chk("t6_size3", rd, 32'hDE55BEEF);

    // 7: misaligned accesses
    run_req(1'b0, 2'b10, 1'b0, 18'h00011, 32'h0, 0, rd, flt, lat);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("t7_fault", 32'(flt), 32'h1);
    chk("t7_data", rd, 32'h0);
    chk("t7_lat", 32'(lat), 32'd1);
    run_req(1'b1, 2'b01, 1'b0, 18'h00013, 32'h0000FFFF, 0, rd, flt, lat);
    chk("t7_st_fault", 32'(flt), 32'h1);
    chk("t7_st_ram", ram[4], 32'hDE55BEEF);
`else
    chk("t7_fault", 32'(flt), 32'h0);
    chk("t7_data", rd, 32'hDE55BEEF);
    chk("t7_lat", 32'(lat), 32'd3);
    run_req(1'b0, 2'b01, 1'b1, 18'h00013, 32'h0, 0, rd, flt, lat);
    chk("t7_half_odd", rd, 32'h0000DE55);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
